// File: rtl/i2c_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_if
// Groups the I2C target's SCL input and its user-side data/status signals.
// SDA stays a plain inout port on the target because it is an open-drain
// wire shared with the master.
//   scl        : I2C clock from the master
//   data_send  : byte returned to the master on reads
//   send_load  : 1-clk pulse when data_send is sampled
//   data_recv  : last byte written by the master
//   recv_valid : 1-clk pulse when data_recv updates
//   busy       : target is engaged in an addressed transfer
// ---------------------------------------------------------------------------
interface i2c_slave_if;
  logic       scl;
  logic [7:0] data_send;
  logic       send_load;
  logic [7:0] data_recv;
  logic       recv_valid;
  logic       busy;

  modport slave (
    input  scl, data_send,
    output send_load, data_recv, recv_valid, busy
  );

  modport master (
    output scl, data_send,
    input  send_load, data_recv, recv_valid, busy
  );
endinterface

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave
// I2C target with a fixed 7-bit address. SCL/SDA are oversampled on clk
// (2-FF synchronizer plus one history FF), START/STOP/SCL edges are decoded
// from the synchronized samples, and a byte-level FSM ACKs the address,
// receives write bytes or returns read bytes. SDA is driven open-drain.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   sda  : I2C data line, driven 1'b0 or released (1'bz)
//   bus  : scl, data_send, send_load, data_recv, recv_valid, busy
// ---------------------------------------------------------------------------
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR   = 7'b1100101,
  parameter int         TIMEOUT_CLKS = 4000
) (
  input  logic           clk,
  input  logic           rst,
  inout  wire            sda,
  i2c_slave_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CLKS);

  logic       scl_meta_q, scl_sync_q, scl_hist_q;
  logic       sda_meta_q, sda_sync_q, sda_hist_q;

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sda_low_q, sda_low_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic [7:0] data_recv_q, data_recv_d;
  logic       recv_valid_q, recv_valid_d;
  logic       send_load_c;
  logic [15:0] tcnt_q, tcnt_d;

  logic scl_rise, scl_fall, start_ev, stop_ev, tmo_armed, tmo_hit;

  // Events are decoded from the synchronized sample versus its history, so
  // they act three clocks after the pin changes.
  assign scl_rise = scl_sync_q & ~scl_hist_q;
  assign scl_fall = ~scl_sync_q & scl_hist_q;
  // START/STOP need SCL stable high across both samples so that an SDA
  // change coincident with an SCL edge is not mistaken for a bus condition.
  assign start_ev = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_ev  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

  assign tmo_armed = (state_q != IDLE) && (state_q != WAIT_STOP);
  assign tmo_hit   = tmo_armed && (tcnt_q >= TMO_LIM);

  assign sda            = sda_low_q ? 1'b0 : 1'bz;
  assign bus.send_load  = send_load_c;
  assign bus.data_recv  = data_recv_q;
  assign bus.recv_valid = recv_valid_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_q   <= 1'b1;
      scl_sync_q   <= 1'b1;
      scl_hist_q   <= 1'b1;
      sda_meta_q   <= 1'b1;
      sda_sync_q   <= 1'b1;
      sda_hist_q   <= 1'b1;
      state_q      <= IDLE;
      bitcnt_q     <= 4'd0;
      sda_low_q    <= 1'b0;
      busy_q       <= 1'b0;
      data_recv_q  <= 8'h00;
      recv_valid_q <= 1'b0;
      tcnt_q       <= 16'd0;
    end else begin
      scl_meta_q   <= bus.scl;
      scl_sync_q   <= scl_meta_q;
      scl_hist_q   <= scl_sync_q;
      sda_meta_q   <= sda;
      sda_sync_q   <= sda_meta_q;
      sda_hist_q   <= sda_sync_q;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      sda_low_q    <= sda_low_d;
      busy_q       <= busy_d;
      data_recv_q  <= data_recv_d;
      recv_valid_q <= recv_valid_d;
      tcnt_q       <= tcnt_d;
    end
    shreg_q <= shreg_d;
    rw_q    <= rw_d;
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    sda_low_d    = sda_low_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    data_recv_d  = data_recv_q;
    recv_valid_d = 1'b0;
    send_load_c  = 1'b0;

    if (scl_rise || scl_fall || !tmo_armed) begin
      tcnt_d = 16'd0;
    end else if (!tmo_hit) begin
      tcnt_d = tcnt_q + 16'd1;
    end else begin
      tcnt_d = tcnt_q;
    end

    if (start_ev) begin
      state_d   = ADDR;
      bitcnt_d  = 4'd0;
      sda_low_d = 1'b0;
    end else if (stop_ev) begin
      state_d   = IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (tmo_hit) begin
      state_d   = IDLE;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;

        ADDR: begin
          if (scl_rise && bitcnt_q != 4'd8) begin
            shreg_d  = {shreg_q[6:0], sda_sync_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            if (shreg_q[7:1] == SLAVE_ADDR) begin
              rw_d      = shreg_q[0];
              sda_low_d = 1'b1;
              busy_d    = 1'b1;
              state_d   = ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = 4'd0;
            if (!rw_q) begin
              sda_low_d = 1'b0;
              state_d   = WR_DATA;
            end else begin
              shreg_d     = bus.data_send;
              sda_low_d   = ~bus.data_send[7];
              send_load_c = 1'b1;
              state_d     = RD_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise && bitcnt_q != 4'd8) begin
            shreg_d  = {shreg_q[6:0], sda_sync_q};
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            data_recv_d  = shreg_q;
            recv_valid_d = 1'b1;
            sda_low_d    = 1'b1;
            state_d      = WR_ACK;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            bitcnt_d  = 4'd0;
            state_d   = WR_DATA;
          end
        end

        // The MSB is already on the bus when this state is entered; each
        // later SCL fall presents the next bit until eight have been clocked.
        RD_DATA: begin
          if (scl_rise && bitcnt_q != 4'd8) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall && bitcnt_q == 4'd8) begin
            sda_low_d = 1'b0;
            state_d   = RD_ACK;
          end else if (scl_fall && bitcnt_q != 4'd0) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            sda_low_d = ~shreg_q[6];
          end
        end

        RD_ACK: begin
          if (scl_rise && sda_sync_q) begin
            state_d = WAIT_STOP;
          end else if (scl_fall) begin
            shreg_d     = bus.data_send;
            sda_low_d   = ~bus.data_send[7];
            send_load_c = 1'b1;
            bitcnt_d    = 4'd0;
            state_d     = RD_DATA;
          end
        end

        WAIT_STOP: sda_low_d = 1'b0;

        default: begin
          state_d   = IDLE;
          sda_low_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;
  localparam logic [6:0] SADDR = 7'b1100101;
  localparam int Q = 25;  // quarter of a 2 us SCL period at 20 ns clk

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  always #10 clk = ~clk;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_if ifc ();

  i2c_slave #(.SLAVE_ADDR(SADDR), .TIMEOUT_CLKS(4000)) dut (
    .clk (clk),
    .rst (rst),
    .sda (sda),
    .bus (ifc.slave)
  );

  int vec = 0;
  int err = 0;
  logic [7:0] exp_recv = 8'h00;

  int recv_cnt = 0, ld_cnt = 0, both_cnt = 0, dut_low_cnt = 0, busy_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (ifc.recv_valid) recv_cnt <= recv_cnt + 1;
      if (ifc.send_load) ld_cnt <= ld_cnt + 1;
      if (ifc.recv_valid && ifc.send_load) both_cnt <= both_cnt + 1;
      if (sda === 1'b0 && !m_low) dut_low_cnt <= dut_low_cnt + 1;
      if (ifc.busy) busy_cnt <= busy_cnt + 1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, required to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master primitives ----------------
  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic m_start();
    m_low = 1'b0; ifc.scl = 1'b1; wt(Q);
    m_low = 1'b1; wt(Q);
    ifc.scl = 1'b0; wt(Q);
  endtask

  task automatic m_rstart();
    m_low = 1'b0; wt(Q);
    ifc.scl = 1'b1; wt(Q);
    m_low = 1'b1; wt(Q);
    ifc.scl = 1'b0; wt(Q);
  endtask

  task automatic m_stop();
    m_low = 1'b1; wt(Q);
    ifc.scl = 1'b1; wt(Q);
    m_low = 1'b0; wt(Q);
  endtask

  task automatic m_wbit(input logic b);
    m_low = ~b; wt(Q);
    ifc.scl = 1'b1; wt(2 * Q);
    ifc.scl = 1'b0; wt(Q);
  endtask

  task automatic m_rbit(output logic b);
    m_low = 1'b0; wt(Q);
    ifc.scl = 1'b1; wt(Q);
    b = (sda !== 1'b0);
    wt(Q);
    ifc.scl = 1'b0; wt(Q);
  endtask

  task automatic m_wbyte(input logic [7:0] v, output logic ack);
    for (int k = 7; k >= 0; k--) m_wbit(v[k]);
    m_rbit(ack);
  endtask

  // One addressed transfer without the closing STOP; reads ACK every byte
  // except the last, which is NACKed.
  task automatic run(input logic [6:0] a, input logic rw, input int n,
                     input logic [7:0] d [3], input logic rs,
                     output logic aack, output logic [2:0] dack,
                     output logic [7:0] r [3]);
    logic b;
    logic [7:0] v;
    dack = 3'b111;
    v = 8'h00;
    for (int i = 0; i < 3; i++) r[i] = 8'h00;
    if (rw) ifc.data_send = d[0];
    if (rs) m_rstart(); else m_start();
    m_wbyte({a, rw}, aack);
    if (!rw) begin
      for (int i = 0; i < n; i++) begin
        m_wbyte(d[i], b);
        dack[i] = b;
      end
    end else if (!aack) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 7; k >= 0; k--) begin
          m_rbit(b);
          v[k] = b;
        end
        r[i] = v;
        if (i + 1 < n) ifc.data_send = d[i + 1];
        m_wbit(i == n - 1);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; wt(3);
    rst = 1'b0; wt(1);
    exp_recv = 8'h00;
    vec++; if (ifc.busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    vec++; if (ifc.recv_valid !== 1'b0) begin err++; $display("FAIL reset_recv_valid: got %b want 0", ifc.recv_valid); end
    vec++; if (ifc.send_load !== 1'b0) begin err++; $display("FAIL reset_send_load: got %b want 0", ifc.send_load); end
    vec++; if (ifc.data_recv !== 8'h00) begin err++; $display("FAIL reset_data_recv: got %h want 00", ifc.data_recv); end
    vec++; if (sda !== 1'b1) begin err++; $display("FAIL reset_sda: got %b want 1", sda); end
  endtask

  task automatic test_write();
    logic aack; logic [2:0] dack; logic [7:0] d [3]; logic [7:0] r [3];
    int rc;
    d = '{8'h63, 8'h00, 8'h00};
    rc = recv_cnt;
    run(SADDR, 1'b0, 1, d, 1'b0, aack, dack, r);
    exp_recv = 8'h63;
    vec++; if (aack !== 1'b0) begin err++; $display("FAIL wr_addr_ack: got %b want 0", aack); end
    vec++; if (dack[0] !== 1'b0) begin err++; $display("FAIL wr_data_ack: got %b want 0", dack[0]); end
    vec++; if (ifc.data_recv !== 8'h63) begin err++; $display("FAIL wr_data_recv: got %h want 63", ifc.data_recv); end
    vec++; if (recv_cnt - rc !== 1) begin err++; $display("FAIL wr_recv_pulses: got %0d want 1", recv_cnt - rc); end
    vec++; if (ifc.busy !== 1'b1) begin err++; $display("FAIL wr_busy_before_stop: got %b want 1", ifc.busy); end
    m_stop(); wt(5);
    vec++; if (ifc.busy !== 1'b0) begin err++; $display("FAIL wr_busy_after_stop: got %b want 0", ifc.busy); end
  endtask

  task automatic test_bad_addr();
    logic aack; logic [2:0] dack; logic [7:0] d [3]; logic [7:0] r [3];
    int rc, lc, bc;
    d = '{8'h5A, 8'h0F, 8'h00};
    rc = recv_cnt; lc = dut_low_cnt; bc = busy_cnt;
    run(7'b0100010, 1'b0, 2, d, 1'b0, aack, dack, r);
    vec++; if (aack !== 1'b1) begin err++; $display("FAIL bad_addr_ack: got %b want 1", aack); end
    vec++; if (dack[1:0] !== 2'b11) begin err++; $display("FAIL bad_data_ack: got %b want 11", dack[1:0]); end
    m_stop(); wt(5);
    vec++; if (dut_low_cnt - lc !== 0) begin err++; $display("FAIL bad_sda_driven: got %0d want 0", dut_low_cnt - lc); end
    vec++; if (busy_cnt - bc !== 0) begin err++; $display("FAIL bad_busy: got %0d want 0", busy_cnt - bc); end
    vec++; if (recv_cnt - rc !== 0) begin err++; $display("FAIL bad_recv_pulses: got %0d want 0", recv_cnt - rc); end
    vec++; if (ifc.data_recv !== exp_recv) begin err++; $display("FAIL bad_data_recv: got %h want %h", ifc.data_recv, exp_recv); end
  endtask

  task automatic test_read();
    logic aack; logic [2:0] dack; logic [7:0] d [3]; logic [7:0] r [3];
    int lc;
    d = '{8'hA5, 8'h00, 8'h00};
    lc = ld_cnt;
    run(SADDR, 1'b1, 1, d, 1'b0, aack, dack, r);
    vec++; if (aack !== 1'b0) begin err++; $display("FAIL rd_addr_ack: got %b want 0", aack); end
    vec++; if (r[0] !== 8'hA5) begin err++; $display("FAIL rd_byte: got %h want a5", r[0]); end
    vec++; if (ld_cnt - lc !== 1) begin err++; $display("FAIL rd_send_load: got %0d want 1", ld_cnt - lc); end
    m_stop(); wt(5);
    vec++; if (ifc.busy !== 1'b0) begin err++; $display("FAIL rd_busy_after_stop: got %b want 0", ifc.busy); end
  endtask

  task automatic test_read2();
    logic aack; logic [2:0] dack; logic [7:0] d [3]; logic [7:0] r [3];
    int lc;
    d = '{8'h3C, 8'hC3, 8'h00};
    lc = ld_cnt;
    run(SADDR, 1'b1, 2, d, 1'b0, aack, dack, r);
    m_stop(); wt(5);
    vec++; if (r[0] !== 8'h3C) begin err++; $display("FAIL rd2_byte0: got %h want 3c", r[0]); end
    vec++; if (r[1] !== 8'hC3) begin err++; $display("FAIL rd2_byte1: got %h want c3", r[1]); end
    vec++; if (ld_cnt - lc !== 2) begin err++; $display("FAIL rd2_send_load: got %0d want 2", ld_cnt - lc); end
  endtask

  task automatic test_rstart();
    logic aack, aack2; logic [2:0] dack; logic [7:0] d [3]; logic [7:0] r [3];
    int rc, lc;
    d = '{8'h96, 8'h00, 8'h00};
    rc = recv_cnt; lc = ld_cnt;
    run(SADDR, 1'b0, 0, d, 1'b0, aack, dack, r);
    run(SADDR, 1'b1, 1, d, 1'b1, aack2, dack, r);
    m_stop(); wt(5);
    vec++; if (aack !== 1'b0 || aack2 !== 1'b0) begin err++; $display("FAIL rs_addr_acks: got %b%b want 00", aack, aack2); end
    vec++; if (r[0] !== 8'h96) begin err++; $display("FAIL rs_read_byte: got %h want 96", r[0]); end
    vec++; if (recv_cnt - rc !== 0) begin err++; $display("FAIL rs_recv_pulses: got %0d want 0", recv_cnt - rc); end
    vec++; if (ld_cnt - lc !== 1) begin err++; $display("FAIL rs_send_load: got %0d want 1", ld_cnt - lc); end
  endtask

  task automatic test_random();
    logic aack; logic [2:0] dack; logic [7:0] d [3]; logic [7:0] r [3];
    logic [6:0] a; logic rw; logic match; int n, rc, lc, dl;
    for (int t = 0; t < 6; t++) begin
      a = ($urandom_range(0, 1) == 1) ? SADDR : 7'($urandom_range(0, 127));
      rw = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      for (int i = 0; i < 3; i++) d[i] = 8'($urandom_range(0, 255));
      match = (a == SADDR);
      rc = recv_cnt; lc = ld_cnt; dl = dut_low_cnt;
      run(a, rw, n, d, 1'b0, aack, dack, r);
      vec++; if (aack !== !match) begin err++; $display("FAIL rnd%0d_addr_ack: got %b want %b", t, aack, !match); end
      if (!rw) begin
        if (match) exp_recv = d[n - 1];
        for (int i = 0; i < n; i++) begin
          vec++; if (dack[i] !== !match) begin err++; $display("FAIL rnd%0d_wr_ack%0d: got %b want %b", t, i, dack[i], !match); end
        end
        vec++; if (recv_cnt - rc !== (match ? n : 0)) begin err++; $display("FAIL rnd%0d_recv_pulses: got %0d want %0d", t, recv_cnt - rc, match ? n : 0); end
        vec++; if (ifc.data_recv !== exp_recv) begin err++; $display("FAIL rnd%0d_data_recv: got %h want %h", t, ifc.data_recv, exp_recv); end
      end else if (match) begin
        for (int i = 0; i < n; i++) begin
          vec++; if (r[i] !== d[i]) begin err++; $display("FAIL rnd%0d_rd_byte%0d: got %h want %h", t, i, r[i], d[i]); end
        end
        vec++; if (ld_cnt - lc !== n) begin err++; $display("FAIL rnd%0d_send_load: got %0d want %0d", t, ld_cnt - lc, n); end
      end
      if (!match) begin
        vec++; if (dut_low_cnt - dl !== 0) begin err++; $display("FAIL rnd%0d_sda_driven: got %0d want 0", t, dut_low_cnt - dl); end
      end
      m_stop(); wt(5);
      vec++; if (ifc.busy !== 1'b0) begin err++; $display("FAIL rnd%0d_busy_after_stop: got %b want 0", t, ifc.busy); end
    end
  endtask

  task automatic test_reset_mid();
    logic aack;
    rst = 1'b1; wt(2); rst = 1'b0; wt(2);
    exp_recv = 8'h00;
    // Reset while the target is holding the address ACK low.
    m_start();
    for (int k = 7; k >= 0; k--) m_wbit(k == 0 ? 1'b0 : SADDR[k - 1]);
    m_low = 1'b0; wt(5);
    vec++; if (sda !== 1'b0) begin err++; $display("FAIL rstm_ack_driven: got %b want 0", sda); end
    rst = 1'b1; wt(1);
    vec++; if (sda !== 1'b1) begin err++; $display("FAIL rstm_ack_release: got %b want 1", sda); end
    rst = 1'b0;
    ifc.scl = 1'b1; wt(Q); m_low = 1'b0; wt(Q);
    // Reset at bit 4 of a write data byte.
    m_start();
    m_wbyte({SADDR, 1'b0}, aack);
    for (int k = 0; k < 4; k++) m_wbit(1'($urandom_range(0, 1)));
    m_low = 1'b0; wt(1);
    vec++; if (ifc.busy !== 1'b1) begin err++; $display("FAIL rstm_busy_before: got %b want 1", ifc.busy); end
    rst = 1'b1; wt(1);
    vec++; if (sda !== 1'b1) begin err++; $display("FAIL rstm_sda: got %b want 1", sda); end
    vec++; if (ifc.busy !== 1'b0) begin err++; $display("FAIL rstm_busy: got %b want 0", ifc.busy); end
    vec++; if (ifc.data_recv !== exp_recv) begin err++; $display("FAIL rstm_data_recv: got %h want %h", ifc.data_recv, exp_recv); end
    rst = 1'b0; wt(2);
    m_stop(); wt(5);
  endtask

  task automatic test_timeout();
    logic aack, b; logic [2:0] dack; logic [7:0] d [3]; logic [7:0] r [3];
    m_start();
    m_wbyte({SADDR, 1'b0}, aack);
    for (int k = 0; k < 3; k++) m_wbit(1'b1);
    vec++; if (ifc.busy !== 1'b1) begin err++; $display("FAIL tmo_busy_before: got %b want 1", ifc.busy); end
    wt(4100);
    vec++; if (ifc.busy !== 1'b0) begin err++; $display("FAIL tmo_busy_after: got %b want 0", ifc.busy); end
    for (int k = 0; k < 5; k++) m_wbit(1'b0);
    m_rbit(b);
    vec++; if (b !== 1'b1) begin err++; $display("FAIL tmo_no_ack_in_idle: got %b want 1", b); end
    m_stop(); wt(5);
    d = '{8'hE7, 8'h00, 8'h00};
    run(SADDR, 1'b0, 1, d, 1'b0, aack, dack, r);
    exp_recv = 8'hE7;
    m_stop(); wt(5);
    vec++; if (aack !== 1'b0 || dack[0] !== 1'b0) begin err++; $display("FAIL tmo_recover_acks: got %b%b want 00", aack, dack[0]); end
    vec++; if (ifc.data_recv !== 8'hE7) begin err++; $display("FAIL tmo_recover_data: got %h want e7", ifc.data_recv); end
  endtask

  initial begin
    ifc.scl = 1'b1;
    ifc.data_send = 8'h00;
    test_reset();
    test_write();
    test_bad_addr();
    test_read();
    test_read2();
    test_rstart();
    test_random();
    test_reset_mid();
    test_timeout();
    vec++; if (both_cnt !== 0) begin err++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
